conv_filter_scheduler: RTL and testbench

- Sequencer that time-shares the single multi-channel 3x3 conv+bias+ReLU core across NUM_FILTERS output filters.
- For each input window (all channels, held stable by the upstream window buffer), it fetches each filter's kernel/bias set from weight memory and pulses the core once per filter.
- It captures each registered core result and presents it on a valid/ready output stream. It runs for cfg_num_windows windows per start.

---
 rtl/conv_sched_pkg.sv | 22 ++
 rtl/conv_filter_scheduler.sv | 135 +++++++++++++
 tb/tb_conv_filter_scheduler.sv | 215 +++++++++++++++++++++
 3 files changed

// File: rtl/conv_sched_pkg.sv
// Shared types and helpers for the conv filter scheduler: FSM state encoding,
// default core sizing and the filter-address width derivation.
package conv_sched_pkg;

  localparam int DEF_NUM_FILTERS  = 4;
  localparam int DEF_RESULT_WIDTH = 24;

  typedef enum logic [2:0] {
    IDLE,
    WAIT_WIN,
    FETCH,
    ISSUE,
    CAPTURE,
    OUT
  } state_e;

  // A single filter still needs a one-bit address so the ports never collapse to zero width.
  function automatic int filt_aw(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/conv_filter_scheduler.sv
// Time-shares one 3x3 conv+bias+ReLU core across NUM_FILTERS filters per input
// window, streaming each captured result out over a valid/ready interface.
module conv_filter_scheduler
  import conv_sched_pkg::*;
#(
  parameter  int NUM_FILTERS  = DEF_NUM_FILTERS,
  parameter  int RESULT_WIDTH = DEF_RESULT_WIDTH,
  parameter  int CNT_WIDTH    = 16,
  localparam int FILT_AW      = filt_aw(NUM_FILTERS)
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    start,
  input  logic [CNT_WIDTH-1:0]    cfg_num_windows,
  output logic                    busy,
  output logic                    done,
  input  logic                    win_valid,
  output logic                    win_ready,
  output logic                    wt_rd_en,
  output logic [FILT_AW-1:0]      wt_rd_addr,
  output logic                    core_valid_in,
  input  logic                    core_valid_out,
  input  logic [RESULT_WIDTH-1:0] core_result,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [RESULT_WIDTH-1:0] out_data,
  output logic [FILT_AW-1:0]      out_filter,
  output logic                    out_last
);

  state_e                 state_q, state_d;
  logic [FILT_AW-1:0]     filt_q;
  logic [CNT_WIDTH-1:0]   win_cnt_q;
  logic [CNT_WIDTH-1:0]   num_win_q;
  logic                   done_q;

  logic last_filt;
  logic last_win;
  logic accept;

  assign last_filt = (filt_q == FILT_AW'(NUM_FILTERS - 1));
  assign last_win  = (win_cnt_q == num_win_q - CNT_WIDTH'(1));
  assign accept    = (state_q == OUT) && out_ready;

  assign busy       = (state_q != IDLE);
  assign done       = done_q;
  assign wt_rd_addr = filt_q;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values, independent of statement order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state_q <= IDLE;
    else        state_q <= state_d;
  end

  // NOTE: every output of this block gets a default first; a path that left
  // one unassigned would infer a latch.
  always_comb begin
    state_d       = state_q;
    win_ready     = 1'b0;
    wt_rd_en      = 1'b0;
    core_valid_in = 1'b0;
    case (state_q)
      IDLE:     if (start && (cfg_num_windows != '0)) state_d = WAIT_WIN;
      WAIT_WIN: if (win_valid) state_d = FETCH;
      FETCH: begin
        wt_rd_en = 1'b1;
        state_d  = ISSUE;
      end
      ISSUE: begin
        core_valid_in = 1'b1;
        state_d       = CAPTURE;
      end
      CAPTURE:  if (core_valid_out) state_d = OUT;
      OUT: begin
        if (out_ready) begin
          if (!last_filt) begin
            state_d = FETCH;
          end else begin
            win_ready = 1'b1;
            state_d   = last_win ? IDLE : WAIT_WIN;
          end
        end
      end
      default:  state_d = IDLE;
    endcase
  end

  // Counters, latched run length and the single-entry output register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      filt_q     <= '0;
      win_cnt_q  <= '0;
      num_win_q  <= '0;
      done_q     <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      out_filter <= '0;
      out_last   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start) begin
            num_win_q <= cfg_num_windows;
            win_cnt_q <= '0;
            filt_q    <= '0;
            if (cfg_num_windows == '0) done_q <= 1'b1;
          end
        end
        WAIT_WIN: if (win_valid) filt_q <= '0;
        CAPTURE: begin
          if (core_valid_out) begin
            out_data   <= core_result;
            out_filter <= filt_q;
            out_valid  <= 1'b1;
            out_last   <= last_filt && last_win;
          end
        end
        default: ;
      endcase
      if (accept) begin
        out_valid <= 1'b0;
        out_last  <= 1'b0;
        if (!last_filt) begin
          filt_q <= filt_q + FILT_AW'(1);
        end else begin
          win_cnt_q <= win_cnt_q + CNT_WIDTH'(1);
          if (last_win) done_q <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_conv_filter_scheduler.sv
// Self-checking bench for conv_filter_scheduler: table of run scenarios with a
// behavioural core/upstream model, plus hand-written reset sequences.
module tb_conv_filter_scheduler;

  localparam int NF  = 4;
  localparam int RW  = 24;
  localparam int CW  = 16;
  localparam int FAW = 2;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          start = 1'b0;
  logic [CW-1:0] cfg_num_windows = '0;
  logic          busy, done;
  logic          win_valid = 1'b0;
  logic          win_ready;
  logic          wt_rd_en;
  logic [FAW-1:0] wt_rd_addr;
  logic          core_valid_in;
  logic          core_valid_out = 1'b0;
  logic [RW-1:0] core_result = '0;
  logic          out_valid;
  logic          out_ready = 1'b0;
  logic [RW-1:0] out_data;
  logic [FAW-1:0] out_filter;
  logic          out_last;

  conv_filter_scheduler #(
    .NUM_FILTERS (NF),
    .RESULT_WIDTH(RW),
    .CNT_WIDTH   (CW)
  ) dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .start          (start),
    .cfg_num_windows(cfg_num_windows),
    .busy           (busy),
    .done           (done),
    .win_valid      (win_valid),
    .win_ready      (win_ready),
    .wt_rd_en       (wt_rd_en),
    .wt_rd_addr     (wt_rd_addr),
    .core_valid_in  (core_valid_in),
    .core_valid_out (core_valid_out),
    .core_result    (core_result),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .out_filter     (out_filter),
    .out_last       (out_last)
  );

  always #5 clk = ~clk;

  // Weight memory + core model: one-cycle registered result, 100 + 16*window + filter.
  int             win_idx = 0;
  logic [FAW-1:0] w_addr_q = '0;
  always @(posedge clk) begin
    if (wt_rd_en) w_addr_q <= wt_rd_addr;
    core_valid_out <= core_valid_in;
    core_result    <= RW'(100 + 16 * win_idx + int'(w_addr_q));
  end

  int n_pass  = 0;
  int n_total = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0d expected %0d", name, act, exp);
  endtask

  typedef struct {
    int n_win;
    int stall_win;
    int stall_filt;
    int stall_cyc;
    int starve;
    int poke_t;
    int exp_done;
  } case_t;

  task automatic run_case(input case_t c);
    int  gap = 0, stall_left = c.stall_cyc, res_idx = 0;
    int  fetch_t = -1, done_t = -1, done_cnt = 0;
    int  busy_cyc = 0, rd_cnt = 0, iss_cnt = 0, viol = 0;
    int  ef, ew;
    bit  waiting = 1'b0, holding = 1'b0;
    logic [RW-1:0]  held_d = '0;
    logic [FAW-1:0] held_f = '0;
    win_idx = 0;
    for (int t = 0; t < 400; t++) begin
      @(posedge clk); #1;
      if (t > 0) gap++;
      start           = (t == 0) || (t == c.poke_t);
      cfg_num_windows = (t == 0) ? CW'(c.n_win) : CW'(7);
      win_valid       = (win_idx < c.n_win) && ((win_idx == 0) || (gap > c.starve));
      if (out_valid && stall_left > 0 && win_idx == c.stall_win && int'(out_filter) == c.stall_filt) begin
        out_ready = 1'b0;
        stall_left--;
      end else begin
        out_ready = 1'b1;
      end
      #1;
      if (busy) busy_cyc++;
      if (wt_rd_en) rd_cnt++;
      if (core_valid_in) iss_cnt++;
      if (core_valid_in && out_valid) viol++;
      if (waiting) begin
        if (win_valid) begin
          waiting = 1'b0;
          fetch_t = t + 1;
        end else if (!busy || wt_rd_en || core_valid_in) begin
          viol++;
        end
      end
      if (t == fetch_t && !(wt_rd_en && wt_rd_addr == '0)) viol++;
      if (holding && (!out_valid || out_data !== held_d || out_filter !== held_f)) viol++;
      holding = out_valid && !out_ready;
      held_d  = out_data;
      held_f  = out_filter;
      if (win_ready && !(out_valid && out_ready)) viol++;
      if (out_valid && out_ready) begin
        ef = res_idx % NF;
        ew = res_idx / NF;
        check("out_data", out_data, 100 + 16 * ew + ef);
        check("out_filter", out_filter, ef);
        check("out_last", out_last, (ew == c.n_win - 1) && (ef == NF - 1));
        check("win_ready", win_ready, ef == NF - 1);
        res_idx++;
        if (win_ready) begin
          win_idx++;
          gap     = 0;
          waiting = (win_idx < c.n_win);
        end
      end
      if (t == 0) waiting = (c.n_win > 0);
      if (done_t >= 0 && t == done_t + 1) begin
        check("done_pulse_width", done, 0);
        break;
      end
      if (done) begin
        done_cnt++;
        if (done_t < 0) done_t = t;
      end
    end
    start = 1'b0;
    win_valid = 1'b0;
    check("done_cycle", done_t, c.exp_done);
    check("done_count", done_cnt, 1);
    check("result_count", res_idx, c.n_win * NF);
    check("rd_count", rd_cnt, c.n_win * NF);
    check("issue_count", iss_cnt, c.n_win * NF);
    check("busy_cycles", busy_cyc, c.exp_done - 1);
    check("protocol_violations", viol, 0);
  endtask

  case_t cases [6];
  int    k, dn;

  initial begin
    // n_win, stall_win, stall_filt, stall_cyc, starve, poke_t, exp_done
    cases[0] = '{1, -1, -1, 0,  0, -1, 18};
    cases[1] = '{0, -1, -1, 0,  0, -1,  1};
    cases[2] = '{2,  0,  2, 5,  0, -1, 40};
    cases[3] = '{2, -1, -1, 0, 10, -1, 45};
    cases[4] = '{3, -1, -1, 0,  0, 10, 52};
    cases[5] = '{1,  0,  3, 2,  0, -1, 20};

    repeat (3) @(posedge clk);
    #1;
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_wt_rd_en", wt_rd_en, 0);
    check("rst_core_valid_in", core_valid_in, 0);
    check("rst_win_ready", win_ready, 0);
    check("rst_out_data", out_data, 0);
    check("rst_out_last", out_last, 0);
    rst_n = 1'b1;

    // Abort a run with reset while a result sits unaccepted in OUT.
    @(posedge clk); #1;
    start = 1'b1; cfg_num_windows = CW'(2); win_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    start = 1'b0;
    k = 0;
    while (!out_valid && k < 20) begin
      @(posedge clk); #1;
      k++;
    end
    check("reach_out_state", out_valid, 1);
    rst_n = 1'b0;
    @(posedge clk); #1;
    check("abort_out_valid", out_valid, 0);
    check("abort_busy", busy, 0);
    check("abort_out_data", out_data, 0);
    check("abort_out_filter", out_filter, 0);
    check("abort_strobes", {wt_rd_en, core_valid_in, win_ready, done, out_last}, 0);
    @(posedge clk); #1;
    rst_n = 1'b1; win_valid = 1'b0; out_ready = 1'b1;
    dn = 0;
    repeat (6) begin
      @(posedge clk); #1;
      if (done || busy) dn++;
    end
    check("no_done_after_abort", dn, 0);

    for (int i = 0; i < 6; i++) run_case(cases[i]);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
